cnn_frame_sequencer: RTL and testbench
======================================

# cnn_frame_sequencer

Synthesizable frame sequencer that streams a bank of stored images into the `cnn` top, one pixel per clock, and collects one classification result per frame. Supports a configurable image size and frame count, per-frame timeout, inter-frame flush gap, abort, and continuous-loop mode. It sits between an on-chip frame memory (1-cycle read latency) and `cnn`'s `valid_in`/`pixel_in` and `valid_out`/`class_out`, and replaces bench-only stimulus for on-board regression.

## Interface
- DATA_WIDTH, 8, pixel width
- IMG_WIDTH, 28, pixels per row
- IMG_HEIGHT, 28, rows per frame; PIXELS = IMG_WIDTH*IMG_HEIGHT
- NUM_FRAMES, 10, frames in memory, frame f at base address f*PIXELS
- CLASS_WIDTH, 4, class index width
- TIMEOUT_CYCLES, 200000, max WAIT cycles per frame (≥2)
- GAP_CYCLES, 30, flush cycles after each result (≥1)
- ADDR_WIDTH, $clog2(NUM_FRAMES*PIXELS), memory address width

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; starts a run (accepted only in IDLE)
- loop_mode  in  1  sampled at start; 1 = wrap to frame 0 after the last frame
- abort  in  1  pulse; ends the run immediately
- mem_rd_en  out  1  frame memory read strobe
- mem_addr  out  ADDR_WIDTH  frame memory address
- mem_rd_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en
- pix_valid  out  1  to cnn valid_in
- pix_data  out  DATA_WIDTH  to cnn pixel_in
- cnn_valid  in  1  from cnn valid_out
- cnn_class  in  CLASS_WIDTH  from cnn class_out
- res_valid  out  1  one-cycle pulse per finished frame
- res_frame  out  $clog2(NUM_FRAMES)  frame index of result
- res_class  out  CLASS_WIDTH  captured class (0 on timeout)
- res_timeout  out  1  frame timed out
- res_match  out  1  !timeout && class == frame index (expected label = index)
- pass_count  out  16  matches in current run, saturating
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at run end (not on abort)

## Operation
- States: IDLE, FEED, WAIT, GAP, DONE.
- IDLE: start -> FEED, frame=0, px=0, pass_count=0, loop_mode latched.
- FEED: mem_rd_en=1, mem_addr=frame*PIXELS+px, px increments each cycle; after px==PIXELS-1 -> WAIT, px=0. pix_valid/pix_data are mem_rd_en/mem_rd_data delayed 1 cycle (registered).
- WAIT: tcnt counts from 0. cnn_valid -> capture class, res_timeout=0, -> GAP. Otherwise, if tcnt==TIMEOUT_CYCLES-1 -> res_timeout=1, res_class=0, -> GAP. cnn_valid in the same cycle as the limit wins (not a timeout).
- cnn_valid outside WAIT is ignored (stale/early output).
- GAP: gcnt counts GAP_CYCLES cycles. Then: if frame<NUM_FRAMES-1 -> frame+1, FEED; else if loop_mode -> frame=0, pass_count kept, FEED; else -> DONE.
- DONE: done=1 for one cycle, -> IDLE.
- abort in any non-IDLE state -> IDLE next cycle; mem_rd_en drops that cycle; the pending pix_valid (already registered) still emits; no res_valid or done. abort has priority over all transitions.
- start while busy is ignored.
- pass_count increments on each res_valid with res_match=1 and saturates at 16'hFFFF.

## Timing
- Reset: all outputs 0; state IDLE; all counters 0.
- start sampled at edge 0 -> first mem_rd_en in cycle 1 -> first pix_valid in cycle 2. pix_valid is high for exactly PIXELS contiguous cycles per frame.
- res_* are registered: res_valid is asserted in the cycle after the capturing WAIT cycle. res_frame/class/timeout/match hold until the next res_valid.
- Minimum frame period = PIXELS + 1 (WAIT) + GAP_CYCLES. Timeout frame period = PIXELS + TIMEOUT_CYCLES + GAP_CYCLES.
- Reset mid-run: immediate return to IDLE; all outputs return to 0.

## Structure
- Package `cnn_pkg`: DATA_WIDTH, CLASS_WIDTH, IMG_WIDTH/IMG_HEIGHT defaults, state enum `seq_state_t`, and the `PIXELS` localparam function.
- Single module. Address generation is `frame_base + px`, with frame_base accumulated by +PIXELS (no multiplier).
- No sub-module needed. The counters (px, tcnt, gcnt) are shared-width local registers.

## Test plan
- Single run: NUM_FRAMES=3, 4x4 image; behavioral cnn returning class=frame index 5 cycles after the last pixel -> 3 res_valid with match=1, pass_count=3, done pulse; exactly 16 pix_valid per frame with data equal to memory contents in order.
- Timeout: TIMEOUT_CYCLES=10, model never responds on frame 1 -> res_timeout=1, res_class=0 at WAIT cycle 10; run continues to frame 2; pass_count=2.
- Race: cnn_valid asserted exactly at tcnt==TIMEOUT_CYCLES-1 -> res_timeout=0, class captured.
- Stray output: cnn_valid pulsed during FEED and GAP -> ignored; no res_valid produced.
- Loop and abort: loop_mode=1 -> frame wraps 2->0 with no done pulse; abort mid-FEED -> mem_rd_en low next cycle, at most one trailing pix_valid, busy=0, no done; a subsequent start restarts from frame 0 with pass_count=0.
- Async reset during WAIT -> all outputs 0 before the next clock edge; start after reset works normally.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN frame sequencer.
package cnn_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int CLASS_WIDTH = 4;
  localparam int IMG_WIDTH   = 28;
  localparam int IMG_HEIGHT  = 28;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_GAP,
    S_DONE
  } seq_state_t;

  function automatic int pixels(input int width, input int height);
    return width * height;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cnn_frame_sequencer.sv
// Streams stored frames into the cnn one pixel per clock and collects one
// classification result (or timeout) per frame.
module cnn_frame_sequencer #(
  parameter int DATA_WIDTH     = cnn_pkg::DATA_WIDTH,
  parameter int IMG_WIDTH      = cnn_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT     = cnn_pkg::IMG_HEIGHT,
  parameter int NUM_FRAMES     = 10,
  parameter int CLASS_WIDTH    = cnn_pkg::CLASS_WIDTH,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int GAP_CYCLES     = 30,
  parameter int ADDR_WIDTH     = $clog2(NUM_FRAMES * IMG_WIDTH * IMG_HEIGHT),
  parameter int FRAME_WIDTH    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   loop_mode,
  input  logic                   abort,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]  mem_rd_data,
  output logic                   pix_valid,
  output logic [DATA_WIDTH-1:0]  pix_data,
  input  logic                   cnn_valid,
  input  logic [CLASS_WIDTH-1:0] cnn_class,
  output logic                   res_valid,
  output logic [FRAME_WIDTH-1:0] res_frame,
  output logic [CLASS_WIDTH-1:0] res_class,
  output logic                   res_timeout,
  output logic                   res_match,
  output logic [15:0]            pass_count,
  output logic                   busy,
  output logic                   done
);
  import cnn_pkg::*;

  localparam int PIXELS    = pixels(IMG_WIDTH, IMG_HEIGHT);
  localparam int CNT_WIDTH = $clog2(max3(PIXELS, TIMEOUT_CYCLES, GAP_CYCLES) + 1);

  localparam logic [CNT_WIDTH-1:0]   PX_LAST      = CNT_WIDTH'(PIXELS - 1);
  localparam logic [CNT_WIDTH-1:0]   TO_LAST      = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   GAP_LAST     = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [FRAME_WIDTH-1:0] FRAME_LAST   = FRAME_WIDTH'(NUM_FRAMES - 1);
  localparam logic [ADDR_WIDTH-1:0]  FRAME_STRIDE = ADDR_WIDTH'(PIXELS);

  seq_state_t             state_reg, state_next;
  logic [CNT_WIDTH-1:0]   cnt_reg;
  logic [FRAME_WIDTH-1:0] frame_reg;
  logic [ADDR_WIDTH-1:0]  frame_base_reg;
  logic                   loop_reg;
  logic                   pix_valid_reg;
  logic                   res_valid_reg;
  logic [FRAME_WIDTH-1:0] res_frame_reg;
  logic [CLASS_WIDTH-1:0] res_class_reg;
  logic                   res_timeout_reg;
  logic                   res_match_reg;
  logic [15:0]            pass_count_reg;

  logic feed_last, wait_hit, gap_last, capture, class_match;

  // One counter serves as px, tcnt and gcnt: it clears on every state change.
  assign feed_last   = (state_reg == S_FEED) && (cnt_reg == PX_LAST);
  assign wait_hit    = (state_reg == S_WAIT) && (cnn_valid || (cnt_reg == TO_LAST));
  assign gap_last    = (state_reg == S_GAP)  && (cnt_reg == GAP_LAST);
  assign capture     = wait_hit && !abort;
  assign class_match = cnn_valid && (int'(cnn_class) == int'(frame_reg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: if (start) state_next = S_FEED;
      S_FEED: if (feed_last) state_next = S_WAIT;
      S_WAIT: if (wait_hit) state_next = S_GAP;
      S_GAP:  if (gap_last) state_next = ((frame_reg != FRAME_LAST) || loop_reg) ? S_FEED : S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort && (state_reg != S_IDLE)) state_next = S_IDLE;
  end

  always_comb begin
    mem_rd_en = (state_reg == S_FEED) && !abort;
    mem_addr  = mem_rd_en ? (frame_base_reg + ADDR_WIDTH'(cnt_reg)) : '0;
    busy      = (state_reg != S_IDLE);
    done      = (state_reg == S_DONE) && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg         <= '0;
      frame_reg       <= '0;
      frame_base_reg  <= '0;
      loop_reg        <= 1'b0;
      pix_valid_reg   <= 1'b0;
      res_valid_reg   <= 1'b0;
      res_frame_reg   <= '0;
      res_class_reg   <= '0;
      res_timeout_reg <= 1'b0;
      res_match_reg   <= 1'b0;
      pass_count_reg  <= '0;
    end else begin
      pix_valid_reg <= mem_rd_en;
      res_valid_reg <= capture;
      cnt_reg <= ((state_next != state_reg) || (state_reg == S_IDLE)) ? '0
                                                                      : cnt_reg + CNT_WIDTH'(1);

      if ((state_reg == S_IDLE) && start) begin
        frame_reg      <= '0;
        frame_base_reg <= '0;
        pass_count_reg <= '0;
        loop_reg       <= loop_mode;
      end

      if (gap_last && (state_next == S_FEED)) begin
        if (frame_reg == FRAME_LAST) begin
          frame_reg      <= '0;
          frame_base_reg <= '0;
        end else begin
          frame_reg      <= frame_reg + FRAME_WIDTH'(1);
          frame_base_reg <= frame_base_reg + FRAME_STRIDE;
        end
      end

      // A result wins over the timeout when both land in the same cycle.
      if (capture) begin
        res_frame_reg   <= frame_reg;
        res_class_reg   <= cnn_valid ? cnn_class : '0;
        res_timeout_reg <= !cnn_valid;
        res_match_reg   <= class_match;
        if (class_match && (pass_count_reg != 16'hFFFF)) begin
          pass_count_reg <= pass_count_reg + 16'd1;
        end
      end
    end
  end

  // The frame memory is the pipeline register, so read data lines up with pix_valid.
  assign pix_valid   = pix_valid_reg;
  assign pix_data    = pix_valid_reg ? mem_rd_data : '0;
  assign res_valid   = res_valid_reg;
  assign res_frame   = res_frame_reg;
  assign res_class   = res_class_reg;
  assign res_timeout = res_timeout_reg;
  assign res_match   = res_match_reg;
  assign pass_count  = pass_count_reg;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer: 3 frames of 4x4, short timeout and gap.
module tb_cnn_frame_sequencer;

  localparam int DW  = 8;
  localparam int NF  = 3;
  localparam int CW  = 4;
  localparam int PIX = 16;
  localparam int AW  = $clog2(NF * PIX);
  localparam int FW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          loop_mode = 1'b0;
  logic          abort = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          cnn_valid = 1'b0;
  logic [CW-1:0] cnn_class = '0;
  logic          res_valid;
  logic [FW-1:0] res_frame;
  logic [CW-1:0] res_class;
  logic          res_timeout;
  logic          res_match;
  logic [15:0]   pass_count;
  logic          busy;
  logic          done;

  cnn_frame_sequencer #(
    .DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4), .NUM_FRAMES(NF),
    .CLASS_WIDTH(CW), .TIMEOUT_CYCLES(10), .GAP_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop_mode(loop_mode), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .cnn_valid(cnn_valid), .cnn_class(cnn_class),
    .res_valid(res_valid), .res_frame(res_frame), .res_class(res_class),
    .res_timeout(res_timeout), .res_match(res_match),
    .pass_count(pass_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Frame memory with one cycle of read latency.
  function automatic logic [DW-1:0] mem_val(input int i);
    return DW'((i * 37 + 11) & 255);
  endfunction

  logic [DW-1:0] mem [NF*PIX];
  initial for (int i = 0; i < NF * PIX; i++) mem[i] = mem_val(i);
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioral cnn: answers resp_d[f] cycles after the last pixel of frame f
  // (negative = never), plus an optional stray pulse mid-FEED.
  int            resp_d [NF];
  int            resp_c [NF];
  int            stray_frame = -1;
  logic [CW-1:0] stray_cls = '0;
  int            mdl_pix = 0, mdl_frame = 0, respond_at = -1, stray_at = -1;
  logic [CW-1:0] resp_cls = '0;

  always @(negedge clk) begin
    if (!rst_n || start) begin
      mdl_pix = 0; mdl_frame = 0; respond_at = -1; stray_at = -1;
    end else if (pix_valid) begin
      mdl_pix++;
      if (mdl_pix == 8 && (mdl_frame % NF) == stray_frame) stray_at = cyc + 1;
      if (mdl_pix == PIX) begin
        mdl_pix = 0;
        if (resp_d[mdl_frame % NF] >= 0) begin
          respond_at = cyc + resp_d[mdl_frame % NF];
          resp_cls   = CW'(resp_c[mdl_frame % NF]);
        end
        mdl_frame++;
      end
    end
    cnn_valid = (cyc == respond_at) || (cyc == stray_at);
    cnn_class = (cyc == respond_at) ? resp_cls : stray_cls;
  end

  typedef struct {
    int frame; int cls; int to; int match; int pass; int lat;
  } res_t;

  res_t          res_q[$];
  logic [DW-1:0] pix_q[$];
  res_t          er;
  logic [DW-1:0] ep;
  int            n_checks = 0, n_fail = 0, done_cnt = 0, mon_pix = 0, last_pix_cyc = 0;
  bit            pix_chk_en = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expected pixels and results whenever the DUT presents one.
  always @(negedge clk) begin
    if (start) mon_pix = 0;
    if (pix_valid && pix_chk_en) begin
      if (pix_q.size() == 0) note_fail("pix_unexpected");
      else begin
        ep = pix_q.pop_front();
        chk("pix_data", int'(pix_data), int'(ep));
      end
      mon_pix++;
      if (mon_pix == PIX) begin
        mon_pix = 0;
        last_pix_cyc = cyc;
      end
    end
    if (res_valid) begin
      $display("result: frame=%0d class=%0d timeout=%0d match=%0d pass=%0d latency=%0d",
               res_frame, res_class, res_timeout, res_match, pass_count, cyc - last_pix_cyc);
      if (res_q.size() == 0) note_fail("res_unexpected");
      else begin
        er = res_q.pop_front();
        chk("res_frame",   int'(res_frame),   er.frame);
        chk("res_class",   int'(res_class),   er.cls);
        chk("res_timeout", int'(res_timeout), er.to);
        chk("res_match",   int'(res_match),   er.match);
        chk("pass_count",  int'(pass_count),  er.pass);
        chk("res_latency", cyc - last_pix_cyc, er.lat);
      end
    end
    if (done) done_cnt++;
  end

  task automatic set_resp(input int d0, input int c0, input int d1, input int c1,
                          input int d2, input int c2);
    resp_d[0] = d0; resp_c[0] = c0;
    resp_d[1] = d1; resp_c[1] = c1;
    resp_d[2] = d2; resp_c[2] = c2;
  endtask

  task automatic push_pix(input int f);
    for (int p = 0; p < PIX; p++) pix_q.push_back(mem_val(f * PIX + p));
  endtask

  task automatic push_res(input int f, input int c, input int to, input int m,
                          input int pass, input int lat);
    res_t r;
    r.frame = f; r.cls = c; r.to = to; r.match = m; r.pass = pass; r.lat = lat;
    res_q.push_back(r);
  endtask

  // Returns in the first FEED cycle.
  task automatic do_start(input logic lm);
    @(negedge clk);
    #1 start = 1'b1; loop_mode = lm; pix_chk_en = 1'b1;
    @(negedge clk);
    #1 start = 1'b0; loop_mode = 1'b0;
  endtask

  task automatic wait_run_end(input string name, input int budget, input int exp_done);
    int n = 0;
    while ((res_q.size() != 0 || done_cnt < exp_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (res_q.size() != 0 || done_cnt < exp_done) note_fail(name);
  endtask

  task automatic push_basic_run();
    for (int f = 0; f < NF; f++) push_pix(f);
    push_res(0, 0, 0, 1, 1, 6);
    push_res(1, 1, 0, 1, 2, 6);
    push_res(2, 2, 0, 1, 3, 6);
  endtask

  initial begin
    int d0, n, trailing;
    set_resp(5, 0, 5, 1, 5, 2);

    repeat (2) @(negedge clk);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mem_rd_en", int'(mem_rd_en), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_pass_count", int'(pass_count), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single run: every frame answered correctly.
    push_basic_run();
    d0 = done_cnt;
    do_start(1'b0);
    chk("first_rd_en", int'(mem_rd_en), 1);
    chk("first_addr", int'(mem_addr), 0);
    chk("first_pix_valid", int'(pix_valid), 0);
    wait_run_end("runA_timeout", 400, d0 + 1);
    @(negedge clk);
    chk("runA_pass", int'(pass_count), 3);
    chk("runA_busy", int'(busy), 0);
    chk("runA_done_pulses", done_cnt - d0, 1);

    // Timeout on frame 1, result exactly at the timeout limit on frame 2.
    set_resp(5, 0, -1, 9, 9, 2);
    for (int f = 0; f < NF; f++) push_pix(f);
    push_res(0, 0, 0, 1, 1, 6);
    push_res(1, 0, 1, 0, 1, 10);
    push_res(2, 2, 0, 1, 2, 10);
    d0 = done_cnt;
    do_start(1'b0);
    wait_run_end("runB_timeout", 400, d0 + 1);
    @(negedge clk);
    chk("runB_pass", int'(pass_count), 2);

    // Stray outputs in GAP (late answer) and FEED must be ignored; wrong class on frame 1.
    set_resp(11, 5, 3, 3, 0, 2);
    stray_frame = 2;
    stray_cls   = 4'd2;
    for (int f = 0; f < NF; f++) push_pix(f);
    push_res(0, 0, 1, 0, 0, 10);
    push_res(1, 3, 0, 0, 0, 4);
    push_res(2, 2, 0, 1, 1, 1);
    d0 = done_cnt;
    do_start(1'b0);
    wait_run_end("runC_timeout", 400, d0 + 1);
    repeat (3) @(negedge clk);
    chk("runC_pass", int'(pass_count), 1);
    stray_frame = -1;

    // Loop mode wraps 2 -> 0 without done; abort during FEED of frame 1.
    set_resp(5, 0, 5, 1, 5, 2);
    push_pix(0); push_pix(1); push_pix(2); push_pix(0); push_pix(1);
    push_res(0, 0, 0, 1, 1, 6);
    push_res(1, 1, 0, 1, 2, 6);
    push_res(2, 2, 0, 1, 3, 6);
    push_res(0, 0, 0, 1, 4, 6);
    d0 = done_cnt;
    do_start(1'b1);
    wait_run_end("runD_timeout", 600, d0);
    n = 0;
    while (!mem_rd_en && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!mem_rd_en) note_fail("runD_no_feed");
    repeat (5) @(negedge clk);
    abort = 1'b1;
    pix_chk_en = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_rd_en", int'(mem_rd_en), 0);
    chk("abort_busy", int'(busy), 0);
    trailing = 0;
    for (int i = 0; i < 4; i++) begin
      if (pix_valid) trailing++;
      @(negedge clk);
    end
    chk("abort_trailing_le1", int'(trailing <= 1), 1);
    chk("abort_no_done", done_cnt - d0, 0);
    pix_q.delete();

    // Restart after abort begins at frame 0 with a cleared pass count.
    push_basic_run();
    d0 = done_cnt;
    do_start(1'b0);
    chk("restart_pass0", int'(pass_count), 0);
    chk("restart_addr", int'(mem_addr), 0);
    wait_run_end("runR_timeout", 400, d0 + 1);
    @(negedge clk);
    chk("runR_pass", int'(pass_count), 3);

    // Asynchronous reset while waiting on frame 1.
    push_pix(0); push_pix(1);
    push_res(0, 0, 0, 1, 1, 6);
    do_start(1'b0);
    n = 0;
    while (mdl_frame < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (mdl_frame < 2) note_fail("rstE_no_wait");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_rd_en", int'(mem_rd_en), 0);
    chk("arst_pix_valid", int'(pix_valid), 0);
    chk("arst_res_match", int'(res_match), 0);
    chk("arst_pass_count", int'(pass_count), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_res_q_empty", res_q.size(), 0);
    pix_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    push_basic_run();
    d0 = done_cnt;
    do_start(1'b0);
    wait_run_end("runF_timeout", 400, d0 + 1);
    @(negedge clk);
    chk("runF_pass", int'(pass_count), 3);
    chk("runF_done_pulses", done_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    note_fail("global_watchdog");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
